alu_div_seq: RTL and testbench
==============================

// Module: alu_div_seq
// PURPOSE
//  Iterative 32-bit integer divider; the inverse companion to the ALU's combinational multiply/add/shift path.
//  The CPU datapath launches X/Y with a Start pulse and stalls on Busy.
//  It takes Result (quotient) and Result_2 (remainder) on Done.
//  Implements RISC-V DIV/DIVU/REM/REMU semantics, including the divide-by-zero and overflow cases.
// PARAMETERS
//  WIDTH      32   operand/result width; the restoring loop runs WIDTH iterations
// PORTS
//  CLK        in   1      system clock, rising edge
//  RST_N      in   1      asynchronous, active-low reset
//  Start      in   1      launch request; sampled only in IDLE
//  Signed     in   1      1 = two's-complement divide, 0 = unsigned; captured with Start
//  X          in   WIDTH  dividend; captured with Start
//  Y          in   WIDTH  divisor; captured with Start
//  Busy       out  1      high while a division is in flight (state != IDLE)
//  Done       out  1      one-cycle pulse; Result/Result_2/DivZero valid from this cycle on
//  Result     out  WIDTH  quotient; held until the next completion
//  Result_2   out  WIDTH  remainder; held until the next completion
//  DivZero    out  1      set with Done when Y==0; cleared on the next completion
// BEHAVIOUR
//  Reset (RST_N=0, any time, mid-operation included):
//   - state=IDLE; Busy=0, Done=0, DivZero=0; Result=0, Result_2=0; iteration counter=0.
//   - An in-flight division is discarded and produces no Done.
//  States:
//   - IDLE: at an edge with Start=1:
//     - Y!=0: latch |X| and |Y| (magnitudes only when Signed=1), latch sign flags sx, sy; go to RUN with cnt=0.
//     - Y==0: at that same edge write Result=all-ones, Result_2=X, DivZero=1, Done=1; stay IDLE (latency 1).
//   - RUN: one restoring step per cycle, with 33-bit partial remainder R:
//     - R' = {R[WIDTH-1:0], Q[MSB]}; Q shifts left.
//     - If R' >= D: R = R'-D and Q[0]=1; else R = R' and Q[0]=0.
//     - cnt increments; after step WIDTH-1 (cnt==WIDTH-1) go to FIX.
//   - FIX: sign correction, then write the outputs and return to IDLE.
//     - Quotient negated if Signed & (sx^sy).
//     - Remainder negated if Signed & sx (remainder takes the dividend's sign).
//     - Write Result/Result_2, DivZero=0, Done=1.
//  Timing:
//   - Start sampled at edge E0; iterations at E1..E32; FIX at E33.
//   - Done is high in the cycle after E33 (latency 33 cycles).
//   - Busy is high from after E0 until E33.
//  Done is combinationally independent of inputs; it drops after exactly one cycle.
//  Start while Busy=1: ignored, no queuing.
//  Start in the Done cycle: accepted, since state is IDLE (back-to-back issue).
//  Signed overflow X=0x80000000, Y=0xFFFFFFFF: falls out of the algorithm as Result=0x80000000, Result_2=0; no special case.
//  Unsigned mode: sign flags forced to 0; magnitudes are the raw operands.
//  All arithmetic is mod 2^WIDTH except the 33-bit compare/subtract in RUN.
//  Outputs are registered; no input-to-output combinational path.
// STRUCTURE
//  Shared package alu_pkg:
//   - div_state_t enum {IDLE, RUN, FIX} (2-bit).
//   - DIV_ZERO_QUOT = all-ones constant.
//   - WIDTH default.
//  Optional sub-module div_step: the combinational single restoring step (R, Q, D in -> R', Q' out).
//  Control FSM and iteration counter ($clog2(WIDTH) bits) live in alu_div_seq.
// TESTING
//  - Unsigned X=100, Y=7 -> Done 33 cycles after Start; Result=14, Result_2=2; DivZero=0; Busy high 33 cycles.
//  - Signed X=-7 (0xFFFFFFF9), Y=2 -> Result=0xFFFFFFFD (-3), Result_2=0xFFFFFFFF (-1); also X=7, Y=-2 -> Result=-3, Result_2=1.
//  - Y=0, X=0x1234 in either mode -> Done next cycle; Result=0xFFFFFFFF, Result_2=0x1234, DivZero=1; Busy never rises.
//  - Signed X=0x80000000, Y=0xFFFFFFFF -> Result=0x80000000, Result_2=0; unsigned same operands -> Result=0, Result_2=0x80000000.
//  - RST_N low 10 cycles after Start -> all outputs 0 asynchronously, no Done; a following 9/3 divide -> Result=3, Result_2=0.
//  - Start pulsed again at cycle 5 of a run -> ignored, first result unchanged; Start asserted in the Done cycle -> second Done 33 cycles later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default datapath width and
// the divide-by-zero quotient constant.
package alu_pkg;

    localparam int DIV_WIDTH = 32;

    // Stored signed so a size cast sign-extends it to all-ones at any width.
    localparam logic signed [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/alu_div_seq_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor when it fits, and emit a quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_sh;
    logic           ge;

    // The remainder entering a step is always below the divisor, so the
    // WIDTH+1-bit shifted value never loses a bit and the difference fits WIDTH.
    assign r_sh  = {r_in, q_in[WIDTH-1]};
    assign ge    = (r_sh >= {1'b0, d_in});
    assign r_out = ge ? WIDTH'(r_sh - {1'b0, d_in}) : r_sh[WIDTH-1:0];
    assign q_out = {q_in[WIDTH-2:0], ge};

endmodule

// File: rtl/alu_div_seq.sv
// Iterative signed/unsigned divider with RISC-V DIV/DIVU/REM/REMU results:
// Start launches, Busy stalls the pipeline, Done pulses when Result/Result_2 are valid.
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_2,
    output logic             DivZero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic             sx, sy, sgn;
    logic             launch, y_zero, last_step;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic signed [WIDTH-1:0] sv;
        sv = signed'(v);
        return neg ? -sv : sv;
    endfunction

    assign y_zero    = (Y == '0);
    assign launch    = (state == IDLE) && Start;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign Busy      = (state != IDLE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (rem_q),
        .q_in  (quo_q),
        .d_in  (dvs_q),
        .r_out (rem_nxt),
        .q_out (quo_nxt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start && !y_zero) state_nxt = RUN;
            RUN:     if (last_step)        state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and architectural outputs; an in-flight operation dies with reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt      <= '0;
            Done     <= 1'b0;
            DivZero  <= 1'b0;
            Result   <= '0;
            Result_2 <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (launch && y_zero) begin
                        Result   <= WIDTH'(DIV_ZERO_QUOT);
                        Result_2 <= X;
                        DivZero  <= 1'b1;
                        Done     <= 1'b1;
                    end
                end
                RUN: cnt <= cnt + 1'b1;
                FIX: begin
                    Result   <= cond_neg(quo_q, sgn & (sx ^ sy));
                    Result_2 <= cond_neg(rem_q, sgn & sx);
                    DivZero  <= 1'b0;
                    Done     <= 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Operand magnitudes and the iterating remainder/quotient pair.
    always_ff @(posedge CLK) begin
        if (launch && !y_zero) begin
            sgn   <= Signed;
            sx    <= Signed & X[WIDTH-1];
            sy    <= Signed & Y[WIDTH-1];
            rem_q <= '0;
            quo_q <= cond_neg(X, Signed & X[WIDTH-1]);
            dvs_q <= cond_neg(Y, Signed & Y[WIDTH-1]);
        end else if (state == RUN) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq: latency, Busy window, signed/unsigned results,
// divide-by-zero, overflow, mid-run reset, ignored Start and back-to-back issue.
module tb_alu_div_seq;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Start = 1'b0;
    logic        Signed = 1'b0;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic        Busy, Done, DivZero;
    logic [31:0] Result, Result_2;

    int total = 0;
    int bad   = 0;
    int lat, busy_n, done_seen;

    alu_div_seq #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Start    (Start),
        .Signed   (Signed),
        .X        (X),
        .Y        (Y),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .Result_2 (Result_2),
        .DivZero  (DivZero)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns edges from launch to Done and
    // the number of post-edge samples with Busy high. poke>0 re-pulses Start
    // with different operands at that point of the run.
    task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                          input int poke, output int l, output int b);
        Signed = s; X = x; Y = y; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        l = 0;
        b = Busy ? 1 : 0;
        while (!Done && l < 100) begin
            if (poke > 0 && l == poke) begin
                Start = 1'b1; Signed = 1'b0; X = 32'd50; Y = 32'd5;
            end else begin
                Start = 1'b0;
            end
            @(posedge CLK); #1;
            l++;
            if (Busy) b++;
        end
        Start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy",    {31'd0, Busy},    32'd0);
        check("rst_done",    {31'd0, Done},    32'd0);
        check("rst_divzero", {31'd0, DivZero}, 32'd0);
        check("rst_result",  Result,           32'd0);
        check("rst_result2", Result_2,         32'd0);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;

        run_op(1'b0, 32'd100, 32'd7, 0, lat, busy_n);
        check("u100_7_lat",  lat, 32'd33);
        check("u100_7_busy", busy_n, 32'd33);
        check("u100_7_q",    Result, 32'd14);
        check("u100_7_r",    Result_2, 32'd2);
        check("u100_7_dz",   {31'd0, DivZero}, 32'd0);
        @(posedge CLK); #1;
        check("done_pulse",  {31'd0, Done}, 32'd0);
        check("q_held",      Result, 32'd14);

        run_op(1'b0, 32'h1234, 32'd0, 0, lat, busy_n);
        check("udz_lat",  lat, 32'd0);
        check("udz_busy", busy_n, 32'd0);
        check("udz_q",    Result, 32'hFFFF_FFFF);
        check("udz_r",    Result_2, 32'h1234);
        check("udz_dz",   {31'd0, DivZero}, 32'd1);
        @(posedge CLK); #1;
        check("udz_done_drop", {31'd0, Done}, 32'd0);
        check("udz_busy_low",  {31'd0, Busy}, 32'd0);

        run_op(1'b1, 32'h1234, 32'd0, 0, lat, busy_n);
        check("sdz_lat", lat, 32'd0);
        check("sdz_busy", busy_n, 32'd0);
        check("sdz_q",   Result, 32'hFFFF_FFFF);
        check("sdz_r",   Result_2, 32'h1234);
        check("sdz_dz",  {31'd0, DivZero}, 32'd1);
        @(posedge CLK); #1;

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, busy_n);
        check("sm7_2_q",  Result, 32'hFFFF_FFFD);
        check("sm7_2_r",  Result_2, 32'hFFFF_FFFF);
        check("sm7_2_dz", {31'd0, DivZero}, 32'd0);
        @(posedge CLK); #1;

        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, lat, busy_n);
        check("s7_m2_q", Result, 32'hFFFF_FFFD);
        check("s7_m2_r", Result_2, 32'd1);
        @(posedge CLK); #1;

        run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, lat, busy_n);
        check("sm100_m7_q", Result, 32'd14);
        check("sm100_m7_r", Result_2, 32'hFFFF_FFFE);
        @(posedge CLK); #1;

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, busy_n);
        check("sovf_q", Result, 32'h8000_0000);
        check("sovf_r", Result_2, 32'd0);
        @(posedge CLK); #1;

        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, busy_n);
        check("uovf_q", Result, 32'd0);
        check("uovf_r", Result_2, 32'h8000_0000);
        @(posedge CLK); #1;

        run_op(1'b0, 32'hFFFF_FFFF, 32'd16, 0, lat, busy_n);
        check("umax_16_q", Result, 32'h0FFF_FFFF);
        check("umax_16_r", Result_2, 32'd15);
        @(posedge CLK); #1;

        // Reset ten cycles into a run
        Signed = 1'b0; X = 32'd100; Y = 32'd7; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_result",  Result, 32'd0);
        check("arst_result2", Result_2, 32'd0);
        check("arst_busy",    {31'd0, Busy}, 32'd0);
        check("arst_done",    {31'd0, Done}, 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (Done) done_seen++;
        end
        check("arst_no_done", done_seen, 32'd0);
        run_op(1'b0, 32'd9, 32'd3, 0, lat, busy_n);
        check("post_rst_lat", lat, 32'd33);
        check("post_rst_q",   Result, 32'd3);
        check("post_rst_r",   Result_2, 32'd0);
        @(posedge CLK); #1;

        run_op(1'b0, 32'd100, 32'd7, 5, lat, busy_n);
        check("poke_lat", lat, 32'd33);
        check("poke_q",   Result, 32'd14);
        check("poke_r",   Result_2, 32'd2);

        // Launch in the Done cycle
        run_op(1'b0, 32'd200, 32'd9, 0, lat, busy_n);
        check("b2b_lat",  lat, 32'd33);
        check("b2b_busy", busy_n, 32'd33);
        check("b2b_q",    Result, 32'd22);
        check("b2b_r",    Result_2, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
